// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
//   Groups the key request and the reset bank outputs of reset_sequencer.
//   Parameter CH : number of reset output channels.
//   Signals      : key     - reset request from the button, active-high
//                  rst_out - per-channel resets, active-high (bit 0 first)
//                  ready   - high once every channel has been released
//   Modports     : master - the sequencer (drives rst_out/ready)
//                  slave  - the board side (drives key, observes resets)
interface reset_sequencer_if #(
    parameter int CH = 4
) ();
    logic          key;
    logic [CH-1:0] rst_out;
    logic          ready;

    modport master (input key, output rst_out, output ready);
    modport slave  (output key, input rst_out, input ready);
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Holds a bank of CH reset outputs asserted for DLY ticks after system
//   reset or a key press, then releases them one at a time, STEP ticks
//   apart, channel 0 first. ready rises with the last channel.
//
//   Ports : clk - system clock
//           rst - asynchronous active-high reset
//           bus - reset_sequencer_if.master (key in, rst_out/ready out)
//
//   Optional build macro RESET_SEQ_DEBOUNCE_EN adds a key debounce filter:
//   the filtered level follows the synchronised key only after the two
//   have disagreed for 2^DEB_W consecutive edges. Without the macro DEB_W
//   is unused.
module reset_sequencer #(
    parameter int               CH    = 4,
    parameter int               DLY_W = 8,
    parameter logic [DLY_W-1:0] DLY   = 8'd255,
    parameter logic [DLY_W-1:0] STEP  = 8'd16,
    parameter int               DEB_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    reset_sequencer_if.master bus
);

    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    // ------------------------------------------------------------------
    // Key synchronisation (and optional debounce)
    // ------------------------------------------------------------------
    logic sync1_reg;
    logic key_s;

`ifdef RESET_SEQ_DEBOUNCE_EN
    logic             sync2_reg;
    logic             deb_reg;
    logic [DEB_W-1:0] deb_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            deb_reg     <= 1'b0;
            deb_cnt_reg <= '0;
        end else begin
            sync1_reg <= bus.key;
            sync2_reg <= sync1_reg;
            // Any agreement restarts the run length; a full run flips the level.
            if (sync2_reg == deb_reg) begin
                deb_cnt_reg <= '0;
            end else if (&deb_cnt_reg) begin
                deb_reg     <= sync2_reg;
                deb_cnt_reg <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    assign key_s = deb_reg;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b0;
        end else begin
            sync1_reg <= bus.key;
        end
    end

    // The FSM registers act as the second synchroniser stage: they react to
    // the value entering that stage, giving a 2-edge pin-to-output latency.
    assign key_s = sync1_reg;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    state_t           state_reg,   state_next;
    logic [DLY_W-1:0] cnt_reg,     cnt_next;
    logic [IDX_W-1:0] idx_reg,     idx_next;
    logic [CH-1:0]    rst_out_reg, rst_out_next;
    logic             ready_reg,   ready_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= HOLD;
            cnt_reg     <= DLY;
            idx_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            rst_out_reg <= rst_out_next;
            ready_reg   <= ready_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        rst_out_next = rst_out_reg;
        ready_next   = ready_reg;

        if (key_s) begin
            // Key wins over any expiring count; a held key keeps reloading.
            state_next   = HOLD;
            cnt_next     = DLY;
            idx_next     = '0;
            rst_out_next = '1;
            ready_next   = 1'b0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else begin
                        rst_out_next[0] = 1'b0;
                        if (CH == 1) begin
                            state_next = RUN;
                            ready_next = 1'b1;
                        end else begin
                            cnt_next   = STEP;
                            idx_next   = IDX_W'(1);
                            state_next = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else begin
                        for (int i = 0; i < CH; i++) begin
                            if (IDX_W'(i) == idx_reg) begin
                                rst_out_next[i] = 1'b0;
                            end
                        end
                        if (idx_reg == IDX_W'(CH - 1)) begin
                            state_next = RUN;
                            ready_next = 1'b1;
                        end else begin
                            cnt_next = STEP;
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                end
                RUN: begin
                    rst_out_next = '0;
                    ready_next   = 1'b1;
                end
                default: begin
                    state_next = HOLD;
                end
            endcase
        end
    end

    assign bus.rst_out = rst_out_reg;
    assign bus.ready   = ready_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Three sequencer instances sharing clk/rst:
//     dut0 : CH=4, DLY=20, STEP=3
//     dut1 : CH=4, DLY=0,  STEP=0
//     dut2 : CH=1, DLY=5
//   Expected per-edge outputs come from a release-time model and are queued
//   before stimulus is applied; a negedge monitor pops and compares them.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   clk_run = 1'b1;
    int   edge_cnt = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int         dut;
        int         edge_no;
        logic [3:0] rst_out;
        logic       ready;
    } exp_t;

    exp_t sb[$];

    reset_sequencer_if #(.CH(4)) if0 ();
    reset_sequencer_if #(.CH(4)) if1 ();
    reset_sequencer_if #(.CH(1)) if2 ();

    reset_sequencer #(.CH(4), .DLY_W(8), .DLY(8'd20), .STEP(8'd3), .DEB_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.master)
    );
    reset_sequencer #(.CH(4), .DLY_W(8), .DLY(8'd0), .STEP(8'd0), .DEB_W(4)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.master)
    );
    reset_sequencer #(.CH(1), .DLY_W(8), .DLY(8'd5), .STEP(8'd16), .DEB_W(4)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.master)
    );

    always #5 if (clk_run) clk = ~clk;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Outputs after edge t when the hold count was (re)loaded at edge base
    // (base=0 for system reset). Returns {ready, rst_out[3:0]}.
    function automatic logic [4:0] model(int ch, int dly, int step, int base, int t);
        logic [3:0] v;
        int         rel;
        v = 4'b0000;
        for (int k = 0; k < ch; k++) begin
            rel = base + dly + 1 + k * (step + 1);
            v[k] = (t < rel);
        end
        rel = base + dly + 1 + (ch - 1) * (step + 1);
        return {(t >= rel), v};
    endfunction

    task automatic push(input int dut, input int t, input logic [4:0] e);
        exp_t x;
        x.dut     = dut;
        x.edge_no = t;
        x.rst_out = e[3:0];
        x.ready   = e[4];
        sb.push_back(x);
    endtask

    // Scoreboard monitor: compare every queued expectation due at this edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] act_v;
        logic       act_r;
        while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin act_v = if0.rst_out;         act_r = if0.ready; end
                1:       begin act_v = if1.rst_out;         act_r = if1.ready; end
                default: begin act_v = {3'b000, if2.rst_out}; act_r = if2.ready; end
            endcase
            if (e.edge_no != edge_cnt)
                check($sformatf("d%0d_e%0d_missed", e.dut, e.edge_no), edge_cnt, e.edge_no);
            check($sformatf("d%0d_e%0d_rst_out", e.dut, e.edge_no), act_v, e.rst_out);
            check($sformatf("d%0d_e%0d_ready", e.dut, e.edge_no), act_r, e.ready);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_d0_rst_out", if0.rst_out, 4'hf);
        check("rst_d0_ready", if0.ready, 1'b0);
        check("rst_d2_rst_out", if2.rst_out, 1'b1);
        #1;
        rst = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic wait_edge(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() > 0) begin
            check("sb_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        if0.key = 1'b0;
        if1.key = 1'b0;
        if2.key = 1'b0;

        // Power-up sequence on all three instances.
        do_reset();
        for (int t = 1; t <= 40; t++) begin
            push(0, t, model(4, 20, 3, 0, t));
            if (t <= 8)  push(1, t, model(4, 0, 0, 0, t));
            if (t <= 10) push(2, t, model(1, 5, 16, 0, t));
        end
        wait_drain();

        // One-cycle key pulse sampled at edge 26 -> reload seen at edge 27.
        do_reset();
        for (int t = 1; t <= 62; t++) begin
            base = (t >= 27) ? 27 : 0;
            push(0, t, model(4, 20, 3, base, t));
        end
        wait_edge(25);
        if0.key = 1'b1;
        wait_edge(26);
        if0.key = 1'b0;
        wait_drain();

        // Asynchronous reset while in RUN with the clock stopped.
        @(negedge clk);
        clk_run = 1'b0;
        #20;
        check("run_d0_ready", if0.ready, 1'b1);
        check("run_d0_rst_out", if0.rst_out, 4'h0);
        rst = 1'b1;
        #1;
        check("async_d0_rst_out", if0.rst_out, 4'hf);
        check("async_d0_ready", if0.ready, 1'b0);
        check("async_d1_rst_out", if1.rst_out, 4'hf);
        check("async_d2_ready", if2.ready, 1'b0);
        #3;
        rst = 1'b0;
        edge_cnt = 0;
        clk_run = 1'b1;

        // Sequence repeats, then the key is held for 100 cycles in RUN:
        // key high at negedges 40..139 -> reload on edges 42..141.
        for (int t = 1; t <= 180; t++) begin
            if (t >= 42 && t <= 141)
                base = t;
            else if (t > 141)
                base = 141;
            else
                base = 0;
            push(0, t, model(4, 20, 3, base, t));
            if (t <= 8)  push(1, t, model(4, 0, 0, 0, t));
            if (t <= 10) push(2, t, model(1, 5, 16, 0, t));
        end
        wait_edge(40);
        if0.key = 1'b1;
        wait_edge(140);
        if0.key = 1'b0;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
